// File: rtl/leaderboard_ctrl.sv
// Sequencer in front of the leaderboard: runs the stopwatch, commits the finished
// time, plays the winning sound on the buzzer, then browses ranks 1-3 before idling.
module leaderboard_ctrl #(
   parameter int TIME_W        = 6,
   parameter int COMMIT_CYCLES = 4,
   parameter int SOUND_TICKS   = 2,
   parameter int DWELL_TICKS   = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_tick,
   input  logic              i_start_btn,
   input  logic              i_stop_btn,
   input  logic [1:0]        i_mode_sel,
   input  logic [TIME_W-1:0] i_sw_time,
   input  logic [2:0]        i_lb_sound,
   output logic              o_sw_run,
   output logic              o_sw_clear,
   output logic [TIME_W-1:0] o_time_in,
   output logic [1:0]        o_stopwatch_mode,
   output logic [2:0]        o_display_mode,
   output logic              o_buzzer_en,
   output logic [1:0]        o_buzzer_sel,
   output logic              o_busy,
   output logic [2:0]        o_state_out
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_COMMIT = 3'd2,
      S_SOUND  = 3'd3,
      S_BROWSE = 3'd4
   } state_t;

   localparam int CC_W = (COMMIT_CYCLES > 1) ? $clog2(COMMIT_CYCLES) : 1;
   localparam int SC_W = (SOUND_TICKS   > 1) ? $clog2(SOUND_TICKS)   : 1;
   localparam int DC_W = (DWELL_TICKS   > 1) ? $clog2(DWELL_TICKS)   : 1;
   localparam logic [CC_W-1:0] CC_LAST = CC_W'(COMMIT_CYCLES - 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SOUND_TICKS - 1);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DWELL_TICKS - 1);

   state_t            r_state;
   logic [CC_W-1:0]   r_commit_cnt;
   logic [SC_W-1:0]   r_sound_cnt;
   logic [DC_W-1:0]   r_dwell_cnt;
   logic              r_sw_run;
   logic              r_sw_clear;
   logic [TIME_W-1:0] r_time_in;
   logic [1:0]        r_stopwatch_mode;
   logic [2:0]        r_display_mode;
   logic              r_buzzer_en;
   logic [1:0]        r_buzzer_sel;
   logic              r_busy;

   logic              w_mode_ok;
   logic              w_start;
   logic [1:0]        w_sel;

   assign w_mode_ok = (i_mode_sel == 2'b01) || (i_mode_sel == 2'b10);
   assign w_start   = i_start_btn && w_mode_ok;

   // Lowest-numbered flag wins the buzzer.
   always_comb begin
      w_sel = 2'd0;
      if (i_lb_sound[0])      w_sel = 2'd1;
      else if (i_lb_sound[1]) w_sel = 2'd2;
      else if (i_lb_sound[2]) w_sel = 2'd3;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state          <= S_IDLE;
         r_commit_cnt     <= '0;
         r_sound_cnt      <= '0;
         r_dwell_cnt      <= '0;
         r_sw_run         <= 1'b0;
         r_sw_clear       <= 1'b0;
         r_time_in        <= '0;
         r_stopwatch_mode <= 2'b00;
         r_display_mode   <= 3'b000;
         r_buzzer_en      <= 1'b0;
         r_buzzer_sel     <= 2'd0;
         r_busy           <= 1'b0;
      end else begin
         r_sw_clear <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_stopwatch_mode <= i_mode_sel;
                  r_sw_clear       <= 1'b1;
                  r_sw_run         <= 1'b1;
                  r_busy           <= 1'b1;
                  r_state          <= S_RUN;
               end
            end
            S_RUN: begin
               // A zero-length run is discarded without touching the leaderboard.
               if (i_stop_btn) begin
                  r_sw_run <= 1'b0;
                  if (i_sw_time == '0) begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_time_in    <= i_sw_time;
                     r_commit_cnt <= '0;
                     r_state      <= S_COMMIT;
                  end
               end
            end
            S_COMMIT: begin
               if (r_commit_cnt == CC_LAST) begin
                  r_commit_cnt <= '0;
                  if (w_sel != 2'd0) begin
                     r_buzzer_en  <= 1'b1;
                     r_buzzer_sel <= w_sel;
                     r_sound_cnt  <= '0;
                     r_state      <= S_SOUND;
                  end else begin
                     r_display_mode <= 3'b100;
                     r_dwell_cnt    <= '0;
                     r_state        <= S_BROWSE;
                  end
               end else begin
                  r_commit_cnt <= r_commit_cnt + 1'b1;
               end
            end
            S_SOUND: begin
               if (i_tick) begin
                  if (r_sound_cnt == SC_LAST) begin
                     r_sound_cnt    <= '0;
                     r_buzzer_en    <= 1'b0;
                     r_buzzer_sel   <= 2'd0;
                     r_display_mode <= 3'b100;
                     r_dwell_cnt    <= '0;
                     r_state        <= S_BROWSE;
                  end else begin
                     r_sound_cnt <= r_sound_cnt + 1'b1;
                  end
               end
            end
            S_BROWSE: begin
               if (w_start) begin
                  r_stopwatch_mode <= i_mode_sel;
                  r_sw_clear       <= 1'b1;
                  r_sw_run         <= 1'b1;
                  r_display_mode   <= 3'b000;
                  r_dwell_cnt      <= '0;
                  r_state          <= S_RUN;
               end else if (i_tick) begin
                  if (r_dwell_cnt == DC_LAST) begin
                     r_dwell_cnt <= '0;
                     if (r_display_mode == 3'b110) begin
                        r_display_mode <= 3'b000;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                     end else begin
                        r_display_mode <= r_display_mode + 3'd1;
                     end
                  end else begin
                     r_dwell_cnt <= r_dwell_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_sw_run         = r_sw_run;
   assign o_sw_clear       = r_sw_clear;
   assign o_time_in        = r_time_in;
   assign o_stopwatch_mode = r_stopwatch_mode;
   assign o_display_mode   = r_display_mode;
   assign o_buzzer_en      = r_buzzer_en;
   assign o_buzzer_sel     = r_buzzer_sel;
   assign o_busy           = r_busy;
   assign o_state_out      = r_state;

endmodule

// File: doc/leaderboard_ctrl.md
Name: leaderboard_ctrl

Overview:
Sequencer in front of the leaderboard block. It starts and stops the stopwatch and latches the finished time and stopwatch mode. It presents the time to the leaderboard in commit mode for a fixed window, then samples the leaderboard's three sound flags. It arbitrates those flags onto a single buzzer channel, then auto-browses ranks 1–3 on display_mode before returning to idle.

Parameters:
TIME_W, 6, width of stopwatch time / leaderboard time_in
COMMIT_CYCLES, 4, clk cycles time_in is held with display_mode=000 before sound flags are sampled (min 2)
SOUND_TICKS, 2, tick periods the buzzer stays on
DWELL_TICKS, 3, tick periods each rank is shown while browsing

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tick  in  1  one-cycle enable, 1 Hz, from clock divider
start_btn  in  1  debounced one-cycle pulse
stop_btn  in  1  debounced one-cycle pulse
mode_sel  in  2  requested stopwatch mode (01 = slow, 10 = fast; 00/11 invalid)
sw_time  in  TIME_W  live stopwatch count
lb_sound  in  3  {signal_sound_3, signal_sound_2, signal_sound_1} from leaderboard
sw_run  out  1  stopwatch count enable
sw_clear  out  1  one-cycle stopwatch clear
time_in  out  TIME_W  registered time to leaderboard
stopwatch_mode  out  2  registered mode to leaderboard
display_mode  out  3  000 = live/commit; 1rr = show rank rr (rr 00..10)
buzzer_en  out  1  buzzer on
buzzer_sel  out  2  winning sound index 1..3 (0 = none)
busy  out  1  high in every state except IDLE
state_out  out  3  current state encoding for debug LEDs

Behaviour:
- Reset (rst_n=0 at clk edge) forces the following from the next edge: state=IDLE, sw_run=0, sw_clear=0, time_in=0, stopwatch_mode=00, display_mode=000, buzzer_en=0, buzzer_sel=0, busy=0, all counters 0. Reset mid-operation aborts any state with no partial commit.
- State encodings: IDLE=0, RUN=1, COMMIT=2, SOUND=3, BROWSE=4.
- IDLE: display_mode=000, sw_run=0.
  - start_btn with valid mode_sel: latch stopwatch_mode<=mode_sel, pulse sw_clear for exactly 1 cycle, go to RUN on the same edge.
  - start_btn with invalid mode_sel: ignored.
  - stop_btn: ignored.
- RUN: sw_run=1. Changes to mode_sel are ignored.
  - stop_btn: sw_run<=0, time_in<=sw_time sampled on that edge.
  - If sw_time==0, return to IDLE with time_in unchanged and no commit. Otherwise go to COMMIT with commit counter=0.
- COMMIT: display_mode=000, time_in held stable.
  - The counter increments each clk. When counter==COMMIT_CYCLES-1, sample lb_sound on that edge.
  - Priority: bit0 > bit1 > bit2, giving buzzer_sel 1/2/3.
  - Any flag set: buzzer_en<=1, go to SOUND. No flag: go to BROWSE.
- SOUND: buzzer_en=1 until SOUND_TICKS tick pulses are counted, then buzzer_en<=0, buzzer_sel<=0, go to BROWSE.
  - A tick coincident with SOUND entry does not count.
- BROWSE: display_mode walks 100 → 101 → 110, advancing after every DWELL_TICKS ticks. After the 110 dwell expires, display_mode<=000 and go to IDLE.
- start_btn in BROWSE aborts the browse and behaves as the IDLE start (mode latch, sw_clear, RUN), provided mode_sel is valid.
- start_btn/stop_btn are ignored in COMMIT and SOUND.
- Simultaneous start_btn and stop_btn: stop wins in RUN; start wins in IDLE/BROWSE.
- Latencies:
  - time_in is valid 1 cycle after stop_btn.
  - The sound decision is made COMMIT_CYCLES cycles after COMMIT entry.
  - All outputs are registered; no combinational path from inputs to outputs.
- stopwatch_mode is held from start until the next valid start; reset clears it.

Test Plan:
- Reset, then mode_sel=01, start, 10 cycles, sw_time=5, stop → sw_clear high 1 cycle; time_in=5 one cycle after stop; stopwatch_mode=01; display_mode=000 for 4 cycles; lb_sound sampled at cycle 4.
- COMMIT with lb_sound=3'b110 → buzzer_sel=2, buzzer_en high for exactly 2 ticks, then display_mode 100/101/110 for 3 ticks each, then 000 and IDLE.
- COMMIT with lb_sound=000 → SOUND skipped, BROWSE entered at cycle 5; buzzer_en never asserted.
- Stop with sw_time=0 → return to IDLE; time_in keeps its previous value; display_mode never leaves 000.
- start_btn during BROWSE at display_mode=101, mode_sel=10 → RUN next cycle, display_mode=000, stopwatch_mode=10, sw_clear pulse. Also: start and stop pulsed in the same cycle in RUN → stop taken.
- rst_n low for one edge during SOUND → all outputs 0 next cycle, state_out=0; a following stop_btn is ignored.
